// File: rtl/sw_cond.sv
// sw_cond: N-channel switch conditioner with a 2-flop synchronizer, a shared tick prescaler and per-bit stable-tick debounce.
// Define SW_COND_EDGE_EN to build the rise_o/fall_o pulses and the sticky chg_o flag; otherwise they are tied low.
module sw_cond #(
  parameter int N            = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 20
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] sw_i,
  input  logic         clr_i,
  output logic [N-1:0] sw_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic         chg_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_cnt [N];
  logic [N-1:0]  r_sw;
  logic          w_tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A bit only counts ticks while its synchronized level disagrees with the
  // accepted level; any agreement (glitch end, reversion) restarts from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sw <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_sync2[i] == r_sw[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_sw[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign sw_o = r_sw;

`ifdef SW_COND_EDGE_EN
  logic [N-1:0] r_sw_d;
  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;
  logic         r_chg;

  // Edges are detected against a one-cycle-delayed copy of sw_o, so pulses
  // land in the cycle after the debounced level changes; set beats clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sw_d <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_sw_d <= r_sw;
      r_rise <= r_sw & ~r_sw_d;
      r_fall <= ~r_sw & r_sw_d;
      if (|(r_sw ^ r_sw_d)) begin
        r_chg <= 1'b1;
      end else if (clr_i) begin
        r_chg <= 1'b0;
      end
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign chg_o  = r_chg;
`else
  logic w_unused_clr;

  assign w_unused_clr = clr_i;
  assign rise_o       = '0;
  assign fall_o       = '0;
  assign chg_o        = 1'b0;
`endif

endmodule

// File: doc/sw_cond.md
SW_COND -- requirements
Module: sw_cond

Interface
REQ-001 SHALL have parameter N, default 16: number of switch channels.
REQ-002 SHALL have parameter TICK_DIV, default 100000: clk cycles per sample tick, minimum 2.
REQ-003 SHALL have parameter STABLE_TICKS, default 20: consecutive ticks needed to accept a new level, minimum 1.
REQ-004 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port sw_i, input, N: raw asynchronous switch/button levels.
REQ-007 SHALL have port clr_i, input, 1: one-cycle clear of chg_o.
REQ-008 SHALL have port sw_o, output, N: debounced levels.
REQ-009 SHALL have port rise_o, output, N: one-cycle pulse per bit on a debounced 0->1 transition.
REQ-010 SHALL have port fall_o, output, N: one-cycle pulse per bit on a debounced 1->0 transition.
REQ-011 SHALL have port chg_o, output, 1: sticky flag, any debounced change since the last clear.

Function
REQ-012 SHALL pass each sw_i bit through a 2-flop synchronizer (sync) before any other use.
REQ-013 SHALL run a shared prescaler counting 0..TICK_DIV-1, then wrapping to 0; tick is high for the one cycle where the prescaler equals TICK_DIV-1.
REQ-014 SHALL keep a per-bit counter of width clog2(STABLE_TICKS+1); the counter is forced to 0 in any cycle where sync[i]==sw_o[i].
REQ-015 SHALL increment the counter of bit i on a tick when sync[i]!=sw_o[i].
REQ-016 SHALL, on the tick where that increment would reach STABLE_TICKS, load sw_o[i]<=sync[i] and set the counter to 0 instead.
REQ-017 SHALL make a glitch shorter than one full tick interval, or any reversion before acceptance, leave sw_o unchanged and restart the count from 0.
REQ-018 SHALL register rise_o and fall_o: high for exactly the cycle after sw_o[i] changes, low otherwise; multiple bits may pulse in the same cycle.
REQ-019 SHALL set chg_o the cycle after any sw_o bit changes and hold it until clr_i; when set and clear coincide, set wins.
REQ-020 SHALL register all outputs; no output combinationally depends on sw_i or clr_i.
REQ-021 SHALL update sw_o at the earliest on the STABLE_TICKS-th tick after the new level reaches sync, which itself takes 2 cycles.

Reset
REQ-022 SHALL asynchronously clear the synchronizer, prescaler, per-bit counters, sw_o, rise_o, fall_o and chg_o to 0 while rstn=0.
REQ-023 SHALL, after reset release, debounce switches that are already high like any 0->1 change, producing a rise_o pulse and setting chg_o.
REQ-024 SHALL abandon any partial debounce when reset is asserted mid-count, with no output pulse.

Configuration
REQ-025 SHALL, with macro SW_COND_EDGE_EN defined, implement rise_o, fall_o and chg_o as described above.
REQ-026 SHALL, without SW_COND_EDGE_EN, tie rise_o, fall_o and chg_o to constant 0, ignore clr_i, and leave sw_o behaviour unchanged.

Verification (TICK_DIV=4, STABLE_TICKS=3, N=16, SW_COND_EDGE_EN defined unless stated)
REQ-027 SHALL cover: rstn=0 with sw_i=16'hFFFF -> all outputs 0 throughout reset.
REQ-028 SHALL cover: sw_i[0] 0->1 held steady -> sw_o[0]=1 on the 3rd tick after sync; rise_o[0] high for 1 cycle; chg_o=1.
REQ-029 SHALL cover: sw_i[3] high for 5 cycles, then low -> sw_o[3] stays 0; no rise_o or fall_o pulse.
REQ-030 SHALL cover: sw_i 16'h0000->16'h8001 steady -> sw_o=16'h8001 in one cycle; rise_o=16'h8001 for 1 cycle; then drop to 16'h0001 -> fall_o=16'h8000 after debounce.
REQ-031 SHALL cover: clr_i pulsed in the same cycle chg_o is being set -> chg_o stays 1; a lone clr_i -> chg_o=0 the next cycle.
REQ-032 SHALL cover: SW_COND_EDGE_EN undefined, run the REQ-028 stimulus -> sw_o identical; rise_o, fall_o and chg_o constantly 0.
